aes_core_arbiter: RTL and testbench
===================================

Name: aes_core_arbiter

Overview:
- Shares one fully pipelined AES-128 encryption core between two requesters.
- The core accepts one plaintext/key pair per cycle and returns the ciphertext with a fixed latency.
- This block arbitrates requests round-robin and drives the core inputs.
- It tracks each issued request's owner through the core latency, routes each result to its owner, and flags any core output that does not line up with an issued request.

Parameters:
- LAT, 10, core latency in cycles from a registered core input to a sampled core output (must be >= 1)
- DW, 128, plaintext/key/ciphertext width

Ports:
- clk, input, 1, clock; all logic is rising-edge
- rst, input, 1, reset; asynchronous, active-low; clears all state
- en, input, 1, issue enable; when low, no new grants, in-flight work drains
- req0_valid, input, 1, requester 0 has a pair
- req0_ready, output, 1, requester 0 grant
- req0_p, input, DW, requester 0 plaintext
- req0_k, input, DW, requester 0 key
- req1_valid, input, 1, requester 1 has a pair
- req1_ready, output, 1, requester 1 grant
- req1_p, input, DW, requester 1 plaintext
- req1_k, input, DW, requester 1 key
- core_p, output, DW, registered plaintext to core
- core_k, output, DW, registered key to core
- core_c, input, DW, ciphertext from core
- core_valid, input, 1, core output valid
- out_valid, output, 1, result valid (one-cycle pulse per result, no backpressure)
- out_id, output, 1, owner of result: 0 or 1
- out_c, output, DW, result ciphertext
- busy, output, 1, at least one request in flight
- err, output, 1, sticky alignment error

Behaviour:
- Reset (rst low, asynchronous):
  - Clears core_p, core_k, out_c, out_valid, out_id, err, the priority pointer and all tag stages to 0.
  - busy, req0_ready and req1_ready read 0 while rst is low.
- Grant (combinational from the valids, en and the priority pointer):
  - en low: both readys are 0.
  - Exactly one valid: that requester is granted.
  - Both valid: the requester named by the priority pointer is granted.
  - At most one ready is high per cycle.
- Transfer: valid & ready at a rising edge.
  - At that edge core_p/core_k load the granted pair.
  - Tag stage 0 loads {1, id}.
  - The priority pointer becomes the non-granted id.
- Edge with no transfer: tag stage 0 loads {0, 0]; core_p/core_k hold their values.
- Tag pipeline:
  - LAT stages shift every edge.
  - A tag loaded at edge n sits in stage LAT-1 after edge n+LAT-1.
  - At edge n+LAT, core_valid/core_c are compared against stage LAT-1.
- Result, at each edge, with T = stage LAT-1:
  - T.valid & core_valid: out_valid<=1, out_id<=T.id, out_c<=core_c.
  - T.valid & !core_valid: err<=1, out_valid<=0 (result lost).
  - !T.valid & core_valid: err<=1, out_valid<=0 (spurious output).
  - Neither: out_valid<=0; out_c and out_id hold.
- End-to-end latency: handshake at edge n gives out_valid high in the cycle after edge n+LAT (LAT+1 cycles).
- Throughput is 1 result/cycle. Results return in issue order.
- err is sticky and is cleared only by reset.
- busy = OR of all tag stage valid bits.
- en falling mid-stream:
  - Pairs already transferred still complete.
  - busy falls LAT edges after the last transfer.
- Reset mid-operation: all in-flight tags are discarded. The core must be reset together with this block; any core_valid seen afterwards with no tag sets err.
- Requester contract: p/k must be held stable while valid is high and ready is low. The block does not check this.

Test Plan:
- Reset, en=1, LAT=10; req0 issues p=3243f6a8885a308d313198a2e0370734, k=2b7e151628aed2a6abf7158809cf4f3c; the core model returns c=3925841d02dc09fbdc118597196a0b32 at edge n+10 -> out_valid high for 1 cycle after edge n+10, out_id=0, out_c matches, err=0.
- req0 and req1 both held valid for 8 cycles -> grants 0,1,0,1,0,1,0,1; 8 results in the same id order, LAT+1 after each grant.
- Only req1 valid for 100 consecutive cycles with FIPS/known vectors -> ready high every cycle; 100 results on consecutive cycles, all out_id=1; busy high throughout and low LAT edges after the last transfer.
- Issue 3 pairs, then drop en -> readys 0 immediately; 3 results still delivered; busy falls LAT edges after the 3rd transfer.
- Core model asserts core_valid with no request issued -> err=1 from the next cycle, out_valid stays 0, err persists until rst.
- Issue 5 pairs, then assert rst low for 2 cycles mid-flight -> all outputs 0 during reset, busy=0, no out_valid afterwards, priority pointer back to requester 0.

Source files
------------

// File: rtl/aes_core_arbiter_if.sv
// Requester-side handshake bundle for the AES core arbiter: one plaintext/key
// pair offered with valid, accepted when ready is returned.
interface aes_core_arbiter_if #(
  parameter int DW = 128
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] p;
  logic [DW-1:0] k;

  modport master (output valid, output p, output k, input ready);
  modport slave  (input valid, input p, input k, output ready);
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin sharing of one fully pipelined AES-128 core between two
// requesters. Each issued pair carries an owner tag through a LAT-deep shift
// register that mirrors the core latency; the tag leaving the last stage is
// matched against core_valid to route the result or flag misalignment.
module aes_core_arbiter #(
  parameter int LAT = 10,
  parameter int DW  = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  aes_core_arbiter_if.slave req0,
  aes_core_arbiter_if.slave req1,
  output logic [DW-1:0] core_p,
  output logic [DW-1:0] core_k,
  input  logic [DW-1:0] core_c,
  input  logic          core_valid,
  output logic          out_valid,
  output logic          out_id,
  output logic [DW-1:0] out_c,
  output logic          busy,
  output logic          err
);

  logic           prio;
  logic           gnt0;
  logic           gnt1;
  logic           xfer;
  logic [LAT-1:0] tag_vld;
  logic [LAT-1:0] tag_id;
  logic           t_vld;
  logic           t_id;

  // Grant: a lone requester wins outright, a tie goes to the priority pointer.
  // rst is folded in so the readys read low while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst && en) begin
      gnt0 = req0.valid && (!req1.valid || !prio);
      gnt1 = req1.valid && (!req0.valid ||  prio);
    end
  end

  assign req0.ready = gnt0;
  assign req1.ready = gnt1;
  assign xfer       = gnt0 | gnt1;

  // Issue stage: register the granted pair into the core and hand priority
  // to the requester that was not served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_p <= '0;
      core_k <= '0;
      prio   <= 1'b0;
    end else if (xfer) begin
      core_p <= gnt1 ? req1.p : req0.p;
      core_k <= gnt1 ? req1.k : req0.k;
      prio   <= gnt0;
    end
  end

  // Tag pipeline: stage 0 records {issued, owner} every edge, later stages
  // shift so stage LAT-1 lines up with the core output of that issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= xfer;
      tag_id[0]  <= gnt1;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign t_vld = tag_vld[LAT-1];
  assign t_id  = tag_id[LAT-1];
  assign busy  = rst && (|tag_vld);

  // Result stage: deliver matched results to their owner; any tag/core_valid
  // disagreement (lost or spurious result) latches the sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      out_c     <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= t_vld && core_valid;
      if (t_vld && core_valid) begin
        out_id <= t_id;
        out_c  <= core_c;
      end
      if (t_vld != core_valid) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: a cycle-stepped driver with a behavioural core
// (fixed-latency delay line) and a queue-based reference of expected results.
module tb_aes_core_arbiter;
  localparam int LAT = 10;
  localparam int DW  = 128;
  localparam int SZ  = 64;
  localparam logic [DW-1:0] FIPS_P = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [DW-1:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [DW-1:0] FIPS_C = 128'h3925841d02dc09fbdc118597196a0b32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [DW-1:0] core_p, core_k, out_c;
  logic [DW-1:0] core_c = '0;
  logic          core_valid = 1'b0;
  logic          out_valid, out_id, busy, err;

  aes_core_arbiter_if #(.DW(DW)) r0_if ();
  aes_core_arbiter_if #(.DW(DW)) r1_if ();

  aes_core_arbiter #(.LAT(LAT), .DW(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .req0(r0_if), .req1(r1_if),
    .core_p(core_p), .core_k(core_k), .core_c(core_c), .core_valid(core_valid),
    .out_valid(out_valid), .out_id(out_id), .out_c(out_c), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic          id;
    logic [DW-1:0] c;
  } exp_t;

  typedef struct {
    logic en, v0, v1, r0, r1;
  } vec_t;

  int n_pass = 0;
  int n_chk  = 0;

  exp_t          q[$];
  int            prio_m = 0;
  logic          err_m = 1'b0, ov_m = 1'b0, oid_m = 1'b0;
  logic [DW-1:0] oc_m = '0;
  logic          sched_v[SZ];
  logic [DW-1:0] sched_c[SZ];
  int            ecnt = 0;

  logic          rst_lvl = 1'b1, want_en = 1'b0, want0 = 1'b0, want1 = 1'b0, spur = 1'b0;
  logic          fips0 = 1'b0, fips1 = 1'b0, need0 = 1'b1, need1 = 1'b1;
  logic [DW-1:0] p0, k0, p1, k1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %h required %h", name, ecnt, act, exp);
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stand-in cipher: exact for the FIPS-197 vector, an arbitrary mix otherwise.
  function automatic logic [DW-1:0] fcore(input logic [DW-1:0] p, input logic [DW-1:0] k);
    logic [DW-1:0] r;
    if (p == FIPS_P && k == FIPS_K) return FIPS_C;
    r = {k[63:0], k[127:64]};
    return p ^ r ^ 128'ha5a5_0f0f_3c3c_9696_5a5a_f0f0_c3c3_6969;
  endfunction

  task automatic cycle(input logic tchk, input logic tr0, input logic tr1);
    logic e0, e1, cv, tagdue, hs0, hs1;
    logic [DW-1:0] cc;
    exp_t it;
    @(negedge clk);
    chk("out_valid", out_valid, ov_m);
    if (ov_m) begin
      chk("out_id", out_id, oid_m);
      chk("out_c", out_c, oc_m);
    end
    chk("err", err, err_m);
    chk("busy", busy, q.size() != 0);

    if (need0) begin p0 = fips0 ? FIPS_P : rnd128(); k0 = fips0 ? FIPS_K : rnd128(); need0 = 1'b0; end
    if (need1) begin p1 = fips1 ? FIPS_P : rnd128(); k1 = fips1 ? FIPS_K : rnd128(); need1 = 1'b0; end
    rst = rst_lvl;
    en  = want_en;
    r0_if.valid = want0; r0_if.p = p0; r0_if.k = k0;
    r1_if.valid = want1; r1_if.p = p1; r1_if.k = k1;
    cv = sched_v[ecnt % SZ] | spur;
    cc = sched_c[ecnt % SZ];
    sched_v[ecnt % SZ] = 1'b0;
    core_valid = cv;
    core_c     = cc;
    #1;

    e0 = 1'b0; e1 = 1'b0;
    if (!rst) begin
      q.delete(); prio_m = 0; err_m = 1'b0; ov_m = 1'b0;
      for (int i = 0; i < SZ; i++) sched_v[i] = 1'b0;
      chk("rst_core_p", core_p, '0);
      chk("rst_core_k", core_k, '0);
      chk("rst_out_c", out_c, '0);
      chk("rst_out_id", out_id, '0);
      chk("rst_out_valid", out_valid, '0);
      chk("rst_err", err, '0);
      chk("rst_busy", busy, '0);
    end else begin
      e0 = en && want0 && (!want1 || prio_m == 0);
      e1 = en && want1 && (!want0 || prio_m == 1);
      tagdue = (q.size() != 0) && (q[0].due == ecnt);
      ov_m = tagdue && cv;
      if (tagdue) begin
        it = q.pop_front();
        if (cv) begin oid_m = it.id; oc_m = it.c; end
      end
      if (tagdue != cv) err_m = 1'b1;
      if (e0 || e1) begin
        it.due = ecnt + LAT;
        it.id  = e1;
        it.c   = e1 ? fcore(p1, k1) : fcore(p0, k0);
        q.push_back(it);
        prio_m = e0 ? 1 : 0;
      end
    end
    chk("req0_ready", r0_if.ready, e0);
    chk("req1_ready", r1_if.ready, e1);
    if (tchk) begin
      chk("tbl_req0_ready", r0_if.ready, tr0);
      chk("tbl_req1_ready", r1_if.ready, tr1);
    end

    hs0 = rst && r0_if.valid && r0_if.ready;
    hs1 = rst && r1_if.valid && r1_if.ready;
    if (hs0 || hs1) begin
      sched_v[(ecnt + LAT) % SZ] = 1'b1;
      sched_c[(ecnt + LAT) % SZ] = hs1 ? fcore(r1_if.p, r1_if.k) : fcore(r0_if.p, r0_if.k);
    end
    if (hs0) need0 = 1'b1;
    if (hs1) need1 = 1'b1;
    @(posedge clk);
    ecnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_lvl = 1'b0;
    run(2);
    rst_lvl = 1'b1;
  endtask

  task automatic idle_drain();
    want0 = 1'b0; want1 = 1'b0;
    run(LAT + 3);
  endtask

  vec_t tbl[10];

  initial begin
    for (int i = 0; i < SZ; i++) begin sched_v[i] = 1'b0; sched_c[i] = '0; end
    r0_if.valid = 1'b0; r0_if.p = '0; r0_if.k = '0;
    r1_if.valid = 1'b0; r1_if.p = '0; r1_if.k = '0;
    #2 rst = 1'b0;
    rst_lvl = 1'b0;
    run(2);
    rst_lvl = 1'b1;
    want_en = 1'b1;

    // Grant sequence from a fresh pointer: {en, v0, v1, ready0, ready1}.
    tbl[0] = '{1, 1, 1, 1, 0};
    tbl[1] = '{1, 1, 1, 0, 1};
    tbl[2] = '{1, 0, 1, 0, 1};
    tbl[3] = '{1, 1, 1, 1, 0};
    tbl[4] = '{0, 1, 1, 0, 0};
    tbl[5] = '{1, 1, 0, 1, 0};
    tbl[6] = '{1, 1, 1, 0, 1};
    tbl[7] = '{1, 0, 0, 0, 0};
    tbl[8] = '{1, 1, 1, 1, 0};
    tbl[9] = '{0, 0, 1, 0, 0};
    for (int i = 0; i < 10; i++) begin
      want_en = tbl[i].en; want0 = tbl[i].v0; want1 = tbl[i].v1;
      cycle(1'b1, tbl[i].r0, tbl[i].r1);
    end
    want_en = 1'b1;
    idle_drain();

    // Single FIPS-197 pair from requester 0.
    fips0 = 1'b1; need0 = 1'b1;
    want0 = 1'b1;
    run(1);
    idle_drain();
    fips0 = 1'b0; need0 = 1'b1;

    // Both requesters contending for 8 cycles after a fresh reset.
    do_reset();
    want0 = 1'b1; want1 = 1'b1;
    run(8);
    idle_drain();

    // Requester 1 alone, back to back for 100 cycles.
    fips1 = 1'b1; need1 = 1'b1;
    want1 = 1'b1;
    run(100);
    idle_drain();
    fips1 = 1'b0; need1 = 1'b1;

    // Three issues, then en drops while requester 0 keeps asking.
    want0 = 1'b1;
    run(3);
    want_en = 1'b0;
    run(LAT + 3);
    want_en = 1'b1;
    idle_drain();

    // Spurious core output with nothing in flight.
    spur = 1'b1;
    run(1);
    spur = 1'b0;
    run(5);

    // Reset with five pairs in flight, then a tie to confirm pointer restart.
    want0 = 1'b1;
    run(5);
    want0 = 1'b0;
    do_reset();
    run(LAT + 3);
    want0 = 1'b1; want1 = 1'b1;
    cycle(1'b1, 1'b1, 1'b0);
    idle_drain();

    // Randomized traffic with occasional en drops, resets and stray outputs.
    for (int i = 0; i < 600; i++) begin
      want0   = ($urandom_range(0, 3) != 0);
      want1   = ($urandom_range(0, 3) != 0);
      want_en = ($urandom_range(0, 7) != 0);
      spur    = ($urandom_range(0, 299) == 0);
      rst_lvl = ($urandom_range(0, 199) != 0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    spur = 1'b0; rst_lvl = 1'b1; want_en = 1'b1;
    idle_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
